// File: rtl/cnn_layer_accel_awe_result_collector_if.sv
// Stream bundle between the AWE multiply chain, the result collector and the output-map writer.
// The collector is the slave: it sinks the macc stream and sources the pixel stream.
interface cnn_layer_accel_awe_result_collector_if #(
    parameter int unsigned C_P_WIDTH   = 48,
    parameter int unsigned C_OUT_WIDTH = 16
);
    logic                   macc_valid;
    logic [C_P_WIDTH-1:0]   macc_p;
    logic                   macc_c;
    logic                   out_valid;
    logic [C_OUT_WIDTH-1:0] out_data;
    logic                   out_ready;

    modport master (
        output macc_valid, macc_p, macc_c, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  macc_valid, macc_p, macc_c, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/cnn_layer_accel_awe_result_collector.sv
// Accumulates partial sums per output pixel, quantizes (round, shift, ReLU, saturate)
// and buffers finished pixels in a small FIFO with a valid/ready output.
module cnn_layer_accel_awe_result_collector #(
    parameter int unsigned C_P_WIDTH         = 48,
    parameter int unsigned C_ACC_WIDTH       = 56,
    parameter int unsigned C_OUT_WIDTH       = 16,
    parameter int unsigned C_DEPTH_CNT_WIDTH = 8,
    parameter int unsigned C_FIFO_DEPTH      = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               new_map,
    input  logic [C_DEPTH_CNT_WIDTH-1:0]       cfg_depth,
    input  logic [5:0]                         cfg_shift,
    input  logic                               cfg_relu,
    cnn_layer_accel_awe_result_collector_if.slave io,
    output logic [$clog2(C_FIFO_DEPTH):0]      fifo_count,
    output logic                               busy,
    output logic                               err_overflow,
    output logic                               err_carry
);
    localparam int unsigned AW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = C_ACC_WIDTH + 1;
    localparam int unsigned DW = C_DEPTH_CNT_WIDTH;
    localparam logic signed [RW-1:0] SAT_MAX = RW'(2**(C_OUT_WIDTH-1) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    logic [DW-1:0]                 cnt_q, cnt_d, depth_q, depth_d, depth_cur;
    logic signed [C_ACC_WIDTH-1:0] acc_q, acc_d, fin_q, fin_d, value, sum;
    logic                          fin_valid_q, fin_valid_d;
    logic [C_OUT_WIDTH-1:0]        q_q, q_d;
    logic                          q_valid_q, q_valid_d;
    logic [C_OUT_WIDTH-1:0]        mem_q [C_FIFO_DEPTH];
    logic [C_OUT_WIDTH-1:0]        mem_d [C_FIFO_DEPTH];
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          out_valid_q, out_valid_d;
    logic [C_OUT_WIDTH-1:0]        out_data_q, out_data_d;
    logic                          busy_q, busy_d;
    logic                          err_overflow_q, err_overflow_d;
    logic                          err_carry_q, err_carry_d;
    logic signed [RW-1:0]          fin_ext, rnd, r, s;
    logic                          full, pop, push_ok;

    // Stage A: window accumulation; depth is latched on the first partial of a window
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        depth_d     = depth_q;
        fin_d       = fin_q;
        fin_valid_d = 1'b0;
        value       = {{(C_ACC_WIDTH-C_P_WIDTH){io.macc_p[C_P_WIDTH-1]}}, io.macc_p};
        depth_cur   = depth_q;
        if (cnt_q == '0) depth_cur = (cfg_depth == '0) ? DW'(1) : cfg_depth;
        sum         = (cnt_q == '0) ? value : acc_q + value;
        if (new_map) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (io.macc_valid) begin
            acc_d   = sum;
            depth_d = depth_cur;
            if (cnt_q + DW'(1) == depth_cur) begin
                fin_d       = sum;
                fin_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    // Stage B: round-half-up, arithmetic shift, optional ReLU, saturate
    always_comb begin
        fin_ext = {fin_q[C_ACC_WIDTH-1], fin_q};
        rnd     = (cfg_shift != 6'd0) ? (RW'(1) <<< (cfg_shift - 6'd1)) : '0;
        r       = fin_ext + rnd;
        s       = r >>> cfg_shift;
        if (cfg_relu && s[RW-1]) s = '0;
        if (s > SAT_MAX)      q_d = SAT_MAX[C_OUT_WIDTH-1:0];
        else if (s < SAT_MIN) q_d = SAT_MIN[C_OUT_WIDTH-1:0];
        else                  q_d = s[C_OUT_WIDTH-1:0];
        q_valid_d = fin_valid_q && !new_map;
    end

    // Stage C: output FIFO; a push onto a full FIFO survives only if the head pops this cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full     = (count_q == CW'(C_FIFO_DEPTH));
        pop      = out_valid_q && io.out_ready;
        push_ok  = q_valid_q && (!full || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = q_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        out_valid_d    = (count_d != '0);
        out_data_d     = mem_d[rd_ptr_d];
        err_overflow_d = err_overflow_q | (q_valid_q && !push_ok);
        err_carry_d    = err_carry_q | (io.macc_valid && io.macc_c);
        busy_d         = (cnt_d != '0) | fin_valid_d | q_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            acc_q          <= '0;
            depth_q        <= '0;
            fin_q          <= '0;
            fin_valid_q    <= 1'b0;
            q_q            <= '0;
            q_valid_q      <= 1'b0;
            for (int i = 0; i < int'(C_FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            busy_q         <= 1'b0;
            err_overflow_q <= 1'b0;
            err_carry_q    <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            depth_q        <= depth_d;
            fin_q          <= fin_d;
            fin_valid_q    <= fin_valid_d;
            q_q            <= q_d;
            q_valid_q      <= q_valid_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            busy_q         <= busy_d;
            err_overflow_q <= err_overflow_d;
            err_carry_q    <= err_carry_d;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_data   = out_data_q;
    assign fifo_count    = count_q;
    assign busy          = busy_q;
    assign err_overflow  = err_overflow_q;
    assign err_carry     = err_carry_q;
endmodule
